// File: rtl/keypad_debounce_encoder.sv
// Keypad synchroniser, press/release debouncer and one-hot-to-code encoder.
// Optional auto-repeat of the valid strobe while a key is held: define KEYPAD_REPEAT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no key accepted, waiting for a clean one-hot input
// DEBOUNCE | candidate key latched, counting stable cycles before accepting
// PRESSED  | key accepted, code on scan_out, waiting for all lines to drop
// RELEASE  | all lines low, counting stable cycles before returning to IDLE
module keypad_debounce_encoder #(
  parameter int N_KEYS        = 12,
  parameter int CODE_W        = 4,
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keypad_in,
  output logic [CODE_W-1:0] scan_out,
  output logic              valid,
  output logic              key_held
);

  localparam int MAX_DR  = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [N_KEYS-1:0]   sync1_q, ks_q;
  logic [N_KEYS-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   scan_q, scan_d;
  logic                valid_q, valid_d;
  logic                key_held_q, key_held_d;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0]    rpt_q, rpt_d;
  logic                rpt_first_q, rpt_first_d;
`endif

  function automatic logic [CODE_W-1:0] encode(input logic [N_KEYS-1:0] oh);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (oh[i]) c = CODE_W'(i + 1);
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    scan_d  = scan_q;
    valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    // Repeat tracking resets whenever we are not sitting in PRESSED.
    rpt_d       = '0;
    rpt_first_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if ($onehot(ks_q)) begin
          cand_d  = ks_q;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (ks_q != cand_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          scan_d  = encode(cand_q);
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (ks_q == '0) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        rpt_first_d = rpt_first_q;
        if (ks_q == cand_q) begin
          if ((!rpt_first_q && rpt_q == RPT_DELAY_LAST) ||
              (rpt_first_q && rpt_q == RPT_PERIOD_LAST)) begin
            valid_d     = 1'b1;
            rpt_d       = '0;
            rpt_first_d = 1'b1;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
`endif
      end
      RELEASE: begin
        if (ks_q != '0)
          state_d = PRESSED;
        else if (cnt_q == DEB_LAST)
          state_d = IDLE;
        else
          cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    key_held_d = (state_d == PRESSED) || (state_d == RELEASE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      ks_q        <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      scan_q      <= '0;
      valid_q     <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= keypad_in;
      ks_q        <= sync1_q;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      scan_q      <= scan_d;
      valid_q     <= valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  assign scan_out = scan_q;
  assign valid    = valid_q;
  assign key_held = key_held_q;

endmodule
